// File: rtl/im_loader.sv
// im_loader: program loader for the writable instruction store.
//
// Accepts a byte-serial program stream on a valid/ready handshake, packs bytes big-endian into
// 32-bit words and issues one write strobe per word at consecutive word addresses from 0. The
// processor is held in reset (cpu_hold) for the whole load.
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   start        begin a load (sampled only while idle)
//   len_words    words to load; clamped to 2^ADDR_W
//   byte_valid   byte_data holds a valid byte this cycle
//   byte_data    program byte, most-significant byte of each word first
//   byte_ready   loader accepts a byte this cycle
//   we           instruction-memory write strobe, one cycle per word
//   waddr        word address of the write
//   wdata        assembled word of the write
//   busy         load in progress
//   cpu_hold     hold processor in reset (same as busy)
//   done         last load completed; cleared when the next start is accepted
//   checksum     XOR of every word written in the current/last load
module im_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;       // one bit wider than waddr so a full-capacity load can finish
  logic [1:0]        cnt_q;       // bytes received for the current word
  logic [31:0]       wdata_q;
  logic [31:0]       checksum_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W:0]   max_len;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   len_one;

  assign max_len     = {1'b1, {ADDR_W{1'b0}}};
  assign len_one     = {{ADDR_W{1'b0}}, 1'b1};
  assign len_clamped = (len_words > max_len) ? max_len : len_words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      checksum_q <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            done_q     <= 1'b0;
            checksum_q <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            len_q      <= len_clamped;
            busy_q     <= 1'b1;
            state_q    <= (len_clamped == '0) ? StDone : StRecv;
          end
        end
        StRecv: begin
          if (byte_valid) begin
            wdata_q <= {wdata_q[23:0], byte_data};
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              // Fourth byte completes the word; strobe is raised together with WRITE.
              we_q    <= 1'b1;
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          checksum_q <= checksum_q ^ wdata_q;
          if (idx_q == len_q - len_one) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + len_one;
            cnt_q   <= '0;
            state_q <= StRecv;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready depends on the state register only, never on byte_valid.
  assign byte_ready = (state_q == StRecv);
  assign we         = we_q;
  assign waddr      = idx_q[ADDR_W-1:0];
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign done       = done_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: the stimulus side pushes expected writes (address, word and,
// for unstalled streams, the exact strobe cycle) into a queue; a negedge monitor pops and
// compares on every write strobe.
module tb_im_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned Cap = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len_words;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          cpu_hold;
  logic          done;
  logic [31:0]   checksum;

  im_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int          cyc;   // -1: strobe cycle not checked
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] stim_words[$];
  int          errors     = 0;
  int          checks     = 0;
  int          n_writes   = 0;
  bit          ready_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && byte_ready) ready_seen = 1'b1;
    if (!reset && we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 64'(waddr), 64'(e.addr));
        check("wdata", 64'(wdata), 64'(e.data));
        if (e.cyc >= 0) check("we_cycle", 64'(cyc), 64'(e.cyc));
      end
      check("ready_during_write", 64'(byte_ready), 64'd0);
      check("hold_during_write", 64'(cpu_hold), 64'd1);
    end
  end

  // mode: 0 continuous, 1 valid every other cycle, 2 random valid.
  task automatic run_load(input int unsigned len, input int mode, input bit stray_start);
    int unsigned lc;
    int          t0;
    int          guard;
    int          wr0;
    bit          v;
    logic [31:0] sum;
    logic [7:0]  bytes[$];

    lc  = (len > Cap) ? Cap : len;
    sum = '0;
    for (int i = 0; i < int'(lc); i++) begin
      sum ^= stim_words[i];
      for (int b = 3; b >= 0; b--) bytes.push_back(stim_words[i][8*b +: 8]);
    end
    wr0 = n_writes;

    @(negedge clk);
    ready_seen = 1'b0;
    start      = 1'b1;
    len_words  = len[AW:0];
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    for (int i = 0; i < int'(lc); i++)
      exp_q.push_back('{addr: i, data: stim_words[i], cyc: (mode == 0) ? t0 + 5*(i+1) - 1 : -1});
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("ready_after_start", 64'(byte_ready), 64'(lc != 0));

    guard = 0;
    while (bytes.size() > 0 && guard < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_data  = v ? bytes[0] : 8'($urandom);
      if (stray_start && guard == 6) begin
        start     = 1'b1;
        len_words = 9'd5;
      end else begin
        start = 1'b0;
      end
      if (v && byte_ready) void'(bytes.pop_front());
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (bytes.size() > 0) check("byte_stream_timeout", 64'(bytes.size()), 64'd0);

    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("done_set", 64'(done), 64'd1);
    if (mode == 0) check("done_cycle", 64'(cyc), 64'(t0 + 5*int'(lc) + 1));
    check("busy_cleared", 64'(busy), 64'd0);
    check("hold_cleared", 64'(cpu_hold), 64'd0);
    check("checksum", 64'(checksum), 64'(sum));
    check("write_count", 64'(n_writes - wr0), 64'(lc));
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    if (lc == 0) check("ready_seen_zero_len", 64'(ready_seen), 64'd0);
    exp_q.delete();
    stim_words.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    len_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    reset = 1'b0;

    // Single word
    stim_words.push_back(32'h3C08_1001);
    run_load(1, 0, 1'b0);

    // Three words with valid toggling
    stim_words.push_back(32'h0000_0001);
    stim_words.push_back(32'h2008_0005);
    stim_words.push_back(32'hAC08_0000);
    run_load(3, 1, 1'b0);

    // Full capacity
    for (int i = 0; i < int'(Cap); i++) stim_words.push_back(32'(i) * 32'h0101_0101);
    run_load(256, 0, 1'b0);

    // Length above capacity is clamped
    for (int i = 0; i < int'(Cap); i++) stim_words.push_back($urandom);
    run_load(300, 0, 1'b0);

    // Zero length
    run_load(0, 0, 1'b0);

    // Reset after six bytes of a two-word load
    @(negedge clk);
    start      = 1'b1;
    len_words  = 9'd2;
    exp_q.push_back('{addr: 0, data: 32'h1122_3344, cyc: -1});
    exp_q.push_back('{addr: 1, data: 32'h5566_7788, cyc: -1});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int g = 0; g < 40 && n < 6; g++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h11 * 8'(n + 1);
      if (byte_ready) n++;
      @(negedge clk);
    end
    byte_valid = 1'b0;
    check("bytes_before_reset", 64'(n), 64'd6);
    check("first_word_written", 64'(exp_q.size()), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", 64'(we), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ready", 64'(byte_ready), 64'd0);
    check("mid_rst_waddr", 64'(waddr), 64'd0);
    check("mid_rst_checksum", 64'(checksum), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    stim_words.push_back(32'hCAFE_F00D);
    run_load(1, 0, 1'b0);

    // Stray start during RECV is ignored
    stim_words.push_back(32'h0BAD_BEEF);
    stim_words.push_back(32'h1357_9BDF);
    run_load(2, 0, 1'b1);

    // Random loads with random stalls
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) stim_words.push_back($urandom);
      run_load(n, 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
